rf_write_queue: RTL and testbench

- Buffered write-back front end for the 32x32 register file: the writer side of the file's single write port.
- Accepts (rd, data) results from the execute/load stages over a valid/ready handshake and queues them in a small FIFO.
- Drains one entry per cycle into the register file write port, unless the port is stalled.
- Provides two combinational forwarding lookups so decode sees values that are still pending in the queue.

---
 rtl/rf_write_queue.sv | 96 +++++++++
 tb/tb_rf_write_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_queue.sv
// Buffered write-back queue feeding the register file's single write port.
// Accepts (rd, data) results, drains one per cycle, and forwards pending values to decode.
module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            rf_stall,
  output logic            rf_en,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [AW-1:0]   q_addr1,
  input  logic [AW-1:0]   q_addr2,
  output logic            q_hit1,
  output logic            q_hit2,
  output logic [XLEN-1:0] q_data1,
  output logic [XLEN-1:0] q_data2,
  output logic [AW-1:0]   count,
  output logic            empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]   ent_rd   [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic [PW-1:0]   idx;

  assign empty    = (count == '0);
  assign in_ready = (count < AW'(DEPTH));
  assign rf_en    = !empty && !rf_stall;
  assign rf_waddr = empty ? '0 : ent_rd[rd_ptr];
  assign rf_wdata = empty ? '0 : ent_data[rd_ptr];
  assign pop      = rf_en;
  // Writes to x0 complete the handshake but are dropped here.
  assign push     = in_valid && in_ready && (in_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_rd[wr_ptr]    <= in_rd;
        ent_data[wr_ptr]  <= in_data;
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      if (push && !pop)
        count <= count + AW'(1);
      else if (pop && !push)
        count <= count - AW'(1);
    end
  end

  // Walk oldest to youngest so a later match overrides, leaving the newest value.
  always_comb begin
    q_hit1  = 1'b0;
    q_hit2  = 1'b0;
    q_data1 = '0;
    q_data2 = '0;
    idx     = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (ent_valid[idx] && (q_addr1 != '0) && (ent_rd[idx] == q_addr1)) begin
        q_hit1  = 1'b1;
        q_data1 = ent_data[idx];
      end
      if (ent_valid[idx] && (q_addr2 != '0) && (ent_rd[idx] == q_addr2)) begin
        q_hit2  = 1'b1;
        q_data2 = ent_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed testbench for rf_write_queue with a behavioural register file that logs every write.
module tb_rf_write_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        rf_stall;
  logic        rf_en;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        q_hit1;
  logic        q_hit2;
  logic [31:0] q_data1;
  logic [31:0] q_data2;
  logic [4:0]  count;
  logic        empty;

  int checks;
  int failures;

  logic [31:0] rf_mem [32];
  logic [4:0]  log_addr [$];
  logic [31:0] log_data [$];

  rf_write_queue #(.DEPTH(4), .XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .rf_stall(rf_stall), .rf_en(rf_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .q_data1(q_data1), .q_data2(q_data2), .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: captures on the same edge the queue pops.
  always @(posedge clk) begin
    if (rf_en === 1'b1) begin
      rf_mem[rf_waddr] <= rf_wdata;
      log_addr.push_back(rf_waddr);
      log_data.push_back(rf_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] d,
                               input logic stall);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    rf_stall = stall;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int n0;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rst = 1'b1;
    q_addr1 = 5'd0;
    q_addr2 = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    $display("[TB] starting rf_write_queue directed test");

    #10;
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_empty", 64'(empty), 64'd1);
    checkOutput("reset_rf_en", 64'(rf_en), 64'd0);
    checkOutput("reset_waddr", 64'(rf_waddr), 64'd0);
    checkOutput("reset_wdata", 64'(rf_wdata), 64'd0);
    rst = 1'b0;

    // Single write with one-cycle latency
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    checkOutput("t1_in_ready", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("t1_rf_en", 64'(rf_en), 64'd1);
    checkOutput("t1_waddr", 64'(rf_waddr), 64'd5);
    checkOutput("t1_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    checkOutput("t1_count1", 64'(count), 64'd1);
    tick();
    checkOutput("t1_count0", 64'(count), 64'd0);
    checkOutput("t1_rf_en_off", 64'(rf_en), 64'd0);
    checkOutput("t1_x5", 64'(rf_mem[5]), 64'hDEADBEEF);
    checkOutput("t1_empty_waddr", 64'(rf_waddr), 64'd0);

    // Fill under stall, hold the fifth push, then drain in order
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h11 * i, 1'b1);
      tick();
    end
    checkOutput("t2_full_count", 64'(count), 64'd4);
    checkOutput("t2_full_ready", 64'(in_ready), 64'd0);
    checkOutput("t2_stall_rf_en", 64'(rf_en), 64'd0);
    checkOutput("t2_head_waddr", 64'(rf_waddr), 64'd1);
    checkOutput("t2_head_wdata", 64'(rf_wdata), 64'h11);
    applyStimulus(1'b1, 5'd5, 32'h55, 1'b1);
    tick();
    tick();
    checkOutput("t2_held_count", 64'(count), 64'd4);
    log_addr.delete();
    log_data.delete();
    applyStimulus(1'b1, 5'd5, 32'h55, 1'b0);
    checkOutput("t2_release_rf_en", 64'(rf_en), 64'd1);
    checkOutput("t2_release_ready", 64'(in_ready), 64'd0);
    tick();
    checkOutput("t2_after_pop_count", 64'(count), 64'd3);
    checkOutput("t2_after_pop_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("t2_pushpop_count", 64'(count), 64'd3);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("t2_drained_count", 64'(count), 64'd0);
    checkOutput("t2_log_size", 64'(log_addr.size()), 64'd5);
    for (int k = 0; k < 5 && k < log_addr.size(); k++) begin
      checkOutput($sformatf("t2_order_addr%0d", k), 64'(log_addr[k]), 64'(k + 1));
      checkOutput($sformatf("t2_order_data%0d", k), 64'(log_data[k]), 64'(32'h11 * (k + 1)));
    end

    // Writes to x0 are accepted and dropped
    n0 = log_addr.size();
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0);
    checkOutput("t3_ready", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("t3_count", 64'(count), 64'd0);
    checkOutput("t3_empty", 64'(empty), 64'd1);
    checkOutput("t3_rf_en", 64'(rf_en), 64'd0);
    tick();
    checkOutput("t3_no_write", 64'(log_addr.size()), 64'(n0));

    // Forwarding returns the youngest pending value
    log_addr.delete();
    log_data.delete();
    applyStimulus(1'b1, 5'd7, 32'hA, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd7, 32'hB, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    q_addr1 = 5'd7;
    q_addr2 = 5'd0;
    #1;
    checkOutput("t4_hit1", 64'(q_hit1), 64'd1);
    checkOutput("t4_data1", 64'(q_data1), 64'hB);
    checkOutput("t4_hit2_x0", 64'(q_hit2), 64'd0);
    checkOutput("t4_data2_x0", 64'(q_data2), 64'd0);
    q_addr2 = 5'd9;
    #1;
    checkOutput("t4_hit2_miss", 64'(q_hit2), 64'd0);
    checkOutput("t4_data2_miss", 64'(q_data2), 64'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("t4_head_wdata", 64'(rf_wdata), 64'hA);
    tick();
    checkOutput("t4_head_hit", 64'(q_hit1), 64'd1);
    checkOutput("t4_head_data", 64'(q_data1), 64'hB);
    tick();
    checkOutput("t4_drained_hit", 64'(q_hit1), 64'd0);
    checkOutput("t4_drained_data", 64'(q_data1), 64'd0);
    checkOutput("t4_x7", 64'(rf_mem[7]), 64'hB);
    checkOutput("t4_log_size", 64'(log_addr.size()), 64'd2);
    q_addr1 = 5'd0;
    q_addr2 = 5'd0;

    // Steady push+pop at count 2 across several pointer wraps
    log_addr.delete();
    log_data.delete();
    applyStimulus(1'b1, 5'd10, 32'h10A, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd11, 32'h10B, 1'b1);
    tick();
    checkOutput("t5_count_start", 64'(count), 64'd2);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 5'(12 + k), 32'h100 + 32'(12 + k), 1'b0);
      tick();
      checkOutput($sformatf("t5_count_k%0d", k), 64'(count), 64'd2);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("t5_drained", 64'(count), 64'd0);
    checkOutput("t5_log_size", 64'(log_addr.size()), 64'd12);
    for (int j = 0; j < 12 && j < log_addr.size(); j++) begin
      checkOutput($sformatf("t5_addr%0d", j), 64'(log_addr[j]), 64'(10 + j));
      checkOutput($sformatf("t5_data%0d", j), 64'(log_data[j]), 64'(32'h100 + 32'(10 + j)));
    end

    // Asynchronous reset discards pending writes
    n0 = log_addr.size();
    applyStimulus(1'b1, 5'd24, 32'hC24, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd25, 32'hC25, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd26, 32'hC26, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("t6_pre_count", 64'(count), 64'd3);
    checkOutput("t6_pre_rf_en", 64'(rf_en), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_rf_en", 64'(rf_en), 64'd0);
    checkOutput("t6_rst_count", 64'(count), 64'd0);
    checkOutput("t6_rst_waddr", 64'(rf_waddr), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("t6_no_writes", 64'(log_addr.size()), 64'(n0));
    checkOutput("t6_x24", 64'(rf_mem[24]), 64'd0);
    checkOutput("t6_x25", 64'(rf_mem[25]), 64'd0);
    checkOutput("t6_x26", 64'(rf_mem[26]), 64'd0);
    checkOutput("t6_ready", 64'(in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
